// File: rtl/shake_msg_packer_if.sv
// rtl/shake_msg_packer_if.sv - message, SHAKE-core and digest signal bundle
// Purpose: groups the message-word stream, the SHAKE core control/return
//          signals and the digest result handshake of shake_msg_packer.
// Ports (signals):
//   s_valid/s_ready/s_data/s_last/s_bytes  message word handshake
//   cfg_mode/cfg_len                       per-message SHAKE configuration
//   sh_start/sh_din/sh_byte_len/sh_mode/sh_out_len_type  to SHAKE core
//   sh_dout/sh_done/sh_busy                from SHAKE core
//   out_valid/out_ready/out_data/out_err   digest result handshake
// Modports: slave = packer side, master = environment side.
interface shake_msg_packer_if;
    logic          s_valid;
    logic          s_ready;
    logic [31:0]   s_data;
    logic          s_last;
    logic [2:0]    s_bytes;
    logic          cfg_mode;
    logic [2:0]    cfg_len;
    logic          sh_start;
    logic [1023:0] sh_din;
    logic [6:0]    sh_byte_len;
    logic          sh_mode;
    logic [2:0]    sh_out_len_type;
    logic [511:0]  sh_dout;
    logic          sh_done;
    logic          sh_busy;
    logic          out_valid;
    logic          out_ready;
    logic [511:0]  out_data;
    logic          out_err;

    modport slave (
        input  s_valid, s_data, s_last, s_bytes, cfg_mode, cfg_len,
        output s_ready,
        output sh_start, sh_din, sh_byte_len, sh_mode, sh_out_len_type,
        input  sh_dout, sh_done, sh_busy,
        output out_valid, out_data, out_err,
        input  out_ready
    );

    modport master (
        output s_valid, s_data, s_last, s_bytes, cfg_mode, cfg_len,
        input  s_ready,
        input  sh_start, sh_din, sh_byte_len, sh_mode, sh_out_len_type,
        output sh_dout, sh_done, sh_busy,
        input  out_valid, out_data, out_err,
        output out_ready
    );
endinterface

// File: rtl/shake_msg_packer.sv
// rtl/shake_msg_packer.sv - packs 32-bit message words into one SHAKE block and returns the digest
// Purpose: collects up to 127 message bytes little-endian into a 1024-bit
//          buffer, fires the SHAKE core once per message, and hands the
//          digest (or an overflow error) out on a valid/ready handshake.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  shake_msg_packer_if.slave (message in, SHAKE core, digest out)
module shake_msg_packer (
    input  logic              clk,
    input  logic              rst,
    shake_msg_packer_if.slave bus
);
    typedef enum logic [2:0] {
        ACCEPT = 3'd0,
        FIRE   = 3'd1,
        WAIT   = 3'd2,
        OUTPUT = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [1023:0] buffer;
    logic [4:0]    word_cnt;
    logic [7:0]    byte_cnt;
    logic          ovf;
    logic          mode_q;
    logic [2:0]    len_q;
    logic          start_q;
    logic          start_d;
    logic          alive;
    logic [511:0]  data_q;
    logic          beat;
    logic [2:0]    nb;
    logic [7:0]    byte_sum;
    logic          over;

    // alive holds s_ready low until the first clock after reset release
    assign bus.s_ready         = alive && ((state == ACCEPT) || (state == DRAIN));
    assign beat                = bus.s_valid && bus.s_ready;
    assign bus.sh_start        = start_q;
    assign bus.sh_din          = buffer;
    assign bus.sh_byte_len     = byte_cnt[6:0];
    assign bus.sh_mode         = mode_q;
    assign bus.sh_out_len_type = len_q;
    assign bus.out_valid       = (state == OUTPUT);
    // data_q is only ever loaded from sh_dout, so an overflowed message reads 0
    assign bus.out_data        = data_q;
    assign bus.out_err         = ovf && (state == OUTPUT);

    // Bytes contributed by this beat; out-of-range s_bytes saturates to 4.
    // The count never exceeds 124+4, so bit 7 alone marks "more than 127".
    always_comb begin
        nb = 3'd4;
        if (bus.s_last && (bus.s_bytes < 3'd4)) begin
            nb = bus.s_bytes;
        end
        byte_sum = byte_cnt + {5'd0, nb};
        over     = byte_sum[7];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ACCEPT;
            start_q <= 1'b0;
        end else begin
            state   <= state_nx;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_nx = state;
        start_d  = 1'b0;
        case (state)
            ACCEPT: begin
                if (beat) begin
                    if (over) begin
                        state_nx = bus.s_last ? OUTPUT : DRAIN;
                    end else if (bus.s_last) begin
                        state_nx = FIRE;
                    end
                end
            end
            FIRE: begin
                // start is registered, so it shows in the first WAIT cycle
                if (!bus.sh_busy) begin
                    start_d  = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (bus.sh_done) begin
                    state_nx = OUTPUT;
                end
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    state_nx = ACCEPT;
                end
            end
            DRAIN: begin
                if (beat && bus.s_last) begin
                    state_nx = OUTPUT;
                end
            end
            default: state_nx = ACCEPT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive    <= 1'b0;
            buffer   <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            ovf      <= 1'b0;
            mode_q   <= 1'b0;
            len_q    <= '0;
            data_q   <= '0;
        end else begin
            alive <= 1'b1;
            if ((state == ACCEPT) && beat) begin
                if (word_cnt == 5'd0) begin
                    mode_q <= bus.cfg_mode;
                    len_q  <= bus.cfg_len;
                end
                for (int j = 0; j < 4; j++) begin
                    if (3'(j) < nb) begin
                        buffer[{word_cnt, 2'(j), 3'b000} +: 8] <= bus.s_data[8*j +: 8];
                    end
                end
                word_cnt <= word_cnt + 5'd1;
                byte_cnt <= byte_sum;
                if (over) begin
                    ovf <= 1'b1;
                end
            end
            if ((state == WAIT) && bus.sh_done) begin
                data_q <= bus.sh_dout;
            end
            if ((state == OUTPUT) && bus.out_ready) begin
                buffer   <= '0;
                word_cnt <= '0;
                byte_cnt <= '0;
                ovf      <= 1'b0;
                mode_q   <= 1'b0;
                len_q    <= '0;
                data_q   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_shake_msg_packer.sv
// tb/tb_shake_msg_packer.sv - self-checking bench for shake_msg_packer
module tb_shake_msg_packer;
    logic clk;
    logic rst;
    int   n_err;
    int   n_chk;
    int   n_starts;

    shake_msg_packer_if bus ();

    shake_msg_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1023:0] din;
        logic [6:0]    len;
        logic          mode;
        logic [2:0]    lt;
        logic          err;
        logic [511:0]  data;
    } exp_t;

    exp_t        q[$];
    logic [31:0] wq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && bus.sh_start) n_starts++;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_s_ready"}, 512'(bus.s_ready), 512'd0);
        chk({pfx, "_sh_start"}, 512'(bus.sh_start), 512'd0);
        chk({pfx, "_sh_din_lo"}, bus.sh_din[511:0], 512'd0);
        chk({pfx, "_sh_din_hi"}, bus.sh_din[1023:512], 512'd0);
        chk({pfx, "_sh_byte_len"}, 512'(bus.sh_byte_len), 512'd0);
        chk({pfx, "_sh_mode"}, 512'(bus.sh_mode), 512'd0);
        chk({pfx, "_sh_out_len_type"}, 512'(bus.sh_out_len_type), 512'd0);
        chk({pfx, "_out_valid"}, 512'(bus.out_valid), 512'd0);
        chk({pfx, "_out_err"}, 512'(bus.out_err), 512'd0);
        chk({pfx, "_out_data"}, bus.out_data, 512'd0);
    endtask

    task automatic fill_rand(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom());
    endtask

    // Builds the expected block from wq, pushes it, then drives every word.
    task automatic send_msg(input logic m, input logic [2:0] lt, input int lb);
        exp_t          e;
        logic [1023:0] b;
        int            tot;
        int            eff;
        int            n;
        int            waitc;
        n   = wq.size();
        eff = (lb > 4) ? 4 : lb;
        b   = '0;
        tot = 0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                if ((i < n - 1) || (j < eff)) begin
                    if (tot < 128) b[8*tot +: 8] = wq[i][8*j +: 8];
                    tot++;
                end
            end
        end
        e.din  = b;
        e.len  = 7'(tot);
        e.mode = m;
        e.lt   = lt;
        e.err  = (tot > 127);
        e.data = '0;
        if (!e.err) begin
            for (int w = 0; w < 16; w++) e.data[32*w +: 32] = $urandom();
        end
        q.push_back(e);
        for (int i = 0; i < n; i++) begin
            bus.s_valid  = 1'b1;
            bus.s_data   = wq[i];
            bus.s_last   = (i == n - 1);
            bus.s_bytes  = (i == n - 1) ? 3'(lb) : 3'($urandom_range(0, 7));
            bus.cfg_mode = (i == 0) ? m : ~m;
            bus.cfg_len  = (i == 0) ? lt : ~lt;
            waitc = 0;
            while (!bus.s_ready && waitc < 50) begin
                @(negedge clk);
                waitc++;
            end
            if (waitc >= 50) chk("s_ready_timeout", 512'(bus.s_ready), 512'd1);
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic run_msg(input logic m, input logic [2:0] lt, input int lb,
                           input int busy, input int done_dly, input int rdy_dly);
        exp_t e;
        int   s0;
        s0 = n_starts;
        bus.sh_busy = (busy > 0);
        send_msg(m, lt, lb);
        e = q.pop_front();
        if (e.err) begin
            chk("err_out_valid", 512'(bus.out_valid), 512'd1);
            chk("err_out_err", 512'(bus.out_err), 512'd1);
            chk("err_out_data", bus.out_data, 512'd0);
            chk("err_s_ready", 512'(bus.s_ready), 512'd0);
            chk("err_no_start", 512'(n_starts), 512'(s0));
        end else begin
            for (int k = 0; k < busy; k++) begin
                chk("start_while_busy", 512'(bus.sh_start), 512'd0);
                @(negedge clk);
            end
            bus.sh_busy = 1'b0;
            @(negedge clk);
            chk("start_pulse", 512'(bus.sh_start), 512'd1);
            chk("sh_din_lo", bus.sh_din[511:0], e.din[511:0]);
            chk("sh_din_hi", bus.sh_din[1023:512], e.din[1023:512]);
            chk("sh_byte_len", 512'(bus.sh_byte_len), 512'(e.len));
            chk("sh_mode", 512'(bus.sh_mode), 512'(e.mode));
            chk("sh_out_len_type", 512'(bus.sh_out_len_type), 512'(e.lt));
            @(negedge clk);
            chk("start_one_cycle", 512'(bus.sh_start), 512'd0);
            chk("start_count", 512'(n_starts), 512'(s0 + 1));
            repeat (done_dly) @(negedge clk);
            bus.sh_dout = e.data;
            bus.sh_done = 1'b1;
            chk("no_valid_before_done", 512'(bus.out_valid), 512'd0);
            @(negedge clk);
            bus.sh_done = 1'b0;
            for (int w = 0; w < 16; w++) bus.sh_dout[32*w +: 32] = $urandom();
            chk("out_err", 512'(bus.out_err), 512'd0);
        end
        for (int k = 0; k < rdy_dly; k++) begin
            chk("hold_out_valid", 512'(bus.out_valid), 512'd1);
            chk("hold_out_data", bus.out_data, e.data);
            chk("hold_s_ready", 512'(bus.s_ready), 512'd0);
            if (!e.err) chk("hold_sh_byte_len", 512'(bus.sh_byte_len), 512'(e.len));
            @(negedge clk);
        end
        chk("out_valid", 512'(bus.out_valid), 512'd1);
        chk("out_data", bus.out_data, e.data);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("back_out_valid", 512'(bus.out_valid), 512'd0);
        chk("back_s_ready", 512'(bus.s_ready), 512'd1);
        chk("back_sh_byte_len", 512'(bus.sh_byte_len), 512'd0);
    endtask

    initial begin
        int s0;
        n_err           = 0;
        n_chk           = 0;
        n_starts        = 0;
        rst             = 1'b0;
        bus.s_valid     = 1'b0;
        bus.s_data      = '0;
        bus.s_last      = 1'b0;
        bus.s_bytes     = '0;
        bus.cfg_mode    = 1'b0;
        bus.cfg_len     = '0;
        bus.sh_dout     = '0;
        bus.sh_done     = 1'b0;
        bus.sh_busy     = 1'b0;
        bus.out_ready   = 1'b0;

        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        rst = 1'b1;
        @(negedge clk);
        chk("s_ready_after_rst", 512'(bus.s_ready), 512'd1);

        // stray sh_done while idle
        bus.sh_dout = {16{32'hdeadbeef}};
        bus.sh_done = 1'b1;
        @(negedge clk);
        bus.sh_done = 1'b0;
        @(negedge clk);
        chk("stray_done_valid", 512'(bus.out_valid), 512'd0);
        chk("stray_done_ready", 512'(bus.s_ready), 512'd1);

        wq = {32'h64636261, 32'h00000065};
        run_msg(1'b0, 3'd0, 1, 0, 2, 0);

        fill_rand(1);
        run_msg(1'b1, 3'd1, 0, 0, 0, 0);

        fill_rand(3);
        run_msg(1'b0, 3'd1, 7, 0, 1, 1);

        fill_rand(4);
        run_msg(1'b1, 3'd0, 2, 5, 1, 0);

        fill_rand(2);
        run_msg(1'b0, 3'd0, 4, 0, 3, 4);

        fill_rand(32);
        run_msg(1'b1, 3'd1, 3, 0, 1, 1);

        fill_rand(32);
        run_msg(1'b0, 3'd1, 4, 0, 0, 2);

        fill_rand(33);
        run_msg(1'b1, 3'd0, 2, 0, 0, 3);

        fill_rand(2);
        run_msg(1'b1, 3'd1, 3, 0, 2, 0);

        // reset while the core is hashing
        fill_rand(3);
        s0 = n_starts;
        send_msg(1'b1, 3'd1, 2);
        void'(q.pop_front());
        @(negedge clk);
        chk("rst_test_started", 512'(bus.sh_start), 512'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_outputs("rst_wait");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wait_s_ready", 512'(bus.s_ready), 512'd1);
        bus.sh_dout = {16{32'h5a5a5a5a}};
        bus.sh_done = 1'b1;
        @(negedge clk);
        bus.sh_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_wait_no_valid", 512'(bus.out_valid), 512'd0);
        end
        chk("rst_wait_start_count", 512'(n_starts), 512'(s0 + 1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
